// File: rtl/nand_phy_calib_pkg.sv
// Shared types and constants for the NAND PHY read-capture calibration sequencer.
package nand_phy_calib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_IDDR,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DECIDE,
    ST_DONE
  } calib_state_t;

  localparam int unsigned PH_0   = 0;
  localparam int unsigned PH_90  = 1;
  localparam int unsigned PH_180 = 2;
  localparam int unsigned PH_270 = 3;
  localparam int unsigned NUM_PH = 4;

  // Bits needed to hold values 0..n_max inclusive.
  function automatic int unsigned cnt_width(input int unsigned n_max);
    return (n_max == 0) ? 1 : int'($clog2(n_max + 1));
  endfunction

endpackage

// File: rtl/nand_phy_calib_bit_cnt.sv
// Per-DQ-bit toggle-error counters over the four phase samples and the
// clk0/clk180 path decision for that bit.
module nand_phy_calib_bit_cnt
  import nand_phy_calib_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 64,
  parameter int unsigned ERR_THRESH  = 4
) (
  input  logic              clk0,
  input  logic              rst0,
  input  logic              clear,
  input  logic              load,
  input  logic              cmp,
  input  logic [NUM_PH-1:0] smp,
  output logic              sel,
  output logic              fail
);

  localparam int unsigned    CW  = cnt_width(NUM_SAMPLES);
  localparam logic [CW-1:0]  SAT = CW'(NUM_SAMPLES);

  logic [NUM_PH-1:0] prev;
  logic [CW-1:0]     err [NUM_PH];
  logic [CW-1:0]     min_err;
  logic              stuck;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      prev <= '0;
      for (int unsigned p = 0; p < NUM_PH; p++) err[p] <= '0;
    end else if (clear) begin
      for (int unsigned p = 0; p < NUM_PH; p++) err[p] <= '0;
    end else if (load || cmp) begin
      prev <= smp;
      // Training data toggles every cycle, so an unchanged sample is an error.
      if (cmp) begin
        for (int unsigned p = 0; p < NUM_PH; p++) begin
          if ((smp[p] == prev[p]) && (err[p] != SAT)) err[p] <= err[p] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel     = (err[PH_0] <= err[PH_180]);
    min_err = sel ? err[PH_0] : err[PH_180];
    stuck   = (err[PH_0] == SAT) && (err[PH_90] == SAT) &&
              (err[PH_180] == SAT) && (err[PH_270] == SAT);
    fail    = (32'(min_err) > ERR_THRESH) || stuck;
  end

endmodule

// File: rtl/nand_phy_calib_ctrl.sv
// Read-capture calibration sequencer for the NAND PHY DQ lanes (clk0 domain).
// Optional NAND_CALIB_RETRY_EN: one automatic re-run after a failing first pass.
module nand_phy_calib_ctrl
  import nand_phy_calib_pkg::*;
#(
  parameter int unsigned DQ_WIDTH      = 8,
  parameter int unsigned NUM_SAMPLES   = 64,
  parameter int unsigned ERR_THRESH    = 4,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                clk0,
  input  logic                rst0,
  input  logic                calib_start,
  output logic                calib_busy,
  output logic                calib_done,
  output logic                calib_fail,
  output logic                calib_train_en,
  output logic                dq_iddr_rst,
  input  logic [DQ_WIDTH-1:0] calib_dq_rise_0,
  input  logic [DQ_WIDTH-1:0] calib_dq_rise_90,
  input  logic [DQ_WIDTH-1:0] calib_dq_rise_180,
  input  logic [DQ_WIDTH-1:0] calib_dq_rise_270,
  output logic [DQ_WIDTH-1:0] calib_clk0_sel
);

  localparam int unsigned MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned SEQ_MAX = (MAX_A > NUM_SAMPLES) ? MAX_A : NUM_SAMPLES;
  localparam int unsigned SEQ_W   = cnt_width(SEQ_MAX);

  localparam logic [SEQ_W-1:0] RST_LAST    = SEQ_W'(RST_CYCLES - 1);
  localparam logic [SEQ_W-1:0] SETTLE_LAST = SEQ_W'(SETTLE_CYCLES - 1);
  localparam logic [SEQ_W-1:0] SAMPLE_LAST = SEQ_W'(NUM_SAMPLES);

  calib_state_t        state;
  logic [SEQ_W-1:0]    seq_cnt;
  logic [DQ_WIDTH-1:0] bit_sel;
  logic [DQ_WIDTH-1:0] bit_fail;
  logic                cnt_clear;
  logic                smp_load;
  logic                smp_cmp;
`ifdef NAND_CALIB_RETRY_EN
  logic                retried;
`endif

  assign cnt_clear = (state == ST_RST_IDDR);
  assign smp_load  = (state == ST_SAMPLE) && (seq_cnt == '0);
  assign smp_cmp   = (state == ST_SAMPLE) && (seq_cnt != '0);

  for (genvar b = 0; b < DQ_WIDTH; b++) begin : g_bit
    logic [NUM_PH-1:0] smp;

    always_comb begin
      smp         = '0;
      smp[PH_0]   = calib_dq_rise_0[b];
      smp[PH_90]  = calib_dq_rise_90[b];
      smp[PH_180] = calib_dq_rise_180[b];
      smp[PH_270] = calib_dq_rise_270[b];
    end

    nand_phy_calib_bit_cnt #(
      .NUM_SAMPLES (NUM_SAMPLES),
      .ERR_THRESH  (ERR_THRESH)
    ) u_bit_cnt (
      .clk0  (clk0),
      .rst0  (rst0),
      .clear (cnt_clear),
      .load  (smp_load),
      .cmp   (smp_cmp),
      .smp   (smp),
      .sel   (bit_sel[b]),
      .fail  (bit_fail[b])
    );
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state          <= ST_IDLE;
      seq_cnt        <= '0;
      calib_busy     <= 1'b0;
      calib_done     <= 1'b0;
      calib_fail     <= 1'b0;
      calib_train_en <= 1'b0;
      dq_iddr_rst    <= 1'b1;
      calib_clk0_sel <= '1;
`ifdef NAND_CALIB_RETRY_EN
      retried        <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (calib_start) begin
            state          <= ST_RST_IDDR;
            seq_cnt        <= '0;
            calib_busy     <= 1'b1;
            calib_done     <= 1'b0;
            calib_fail     <= 1'b0;
            calib_train_en <= 1'b0;
            dq_iddr_rst    <= 1'b1;
`ifdef NAND_CALIB_RETRY_EN
            retried        <= 1'b0;
`endif
          end
        end
        ST_RST_IDDR: begin
          if (seq_cnt == RST_LAST) begin
            state          <= ST_SETTLE;
            seq_cnt        <= '0;
            dq_iddr_rst    <= 1'b0;
            calib_train_en <= 1'b1;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (seq_cnt == SETTLE_LAST) begin
            state   <= ST_SAMPLE;
            seq_cnt <= '0;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (seq_cnt == SAMPLE_LAST) begin
            state          <= ST_DECIDE;
            seq_cnt        <= '0;
            calib_train_en <= 1'b0;
          end else begin
            seq_cnt <= seq_cnt + 1'b1;
          end
        end
        ST_DECIDE: begin
          // A failing first pass re-enters the reset phase; busy stays high.
`ifdef NAND_CALIB_RETRY_EN
          if ((|bit_fail) && !retried) begin
            state       <= ST_RST_IDDR;
            seq_cnt     <= '0;
            dq_iddr_rst <= 1'b1;
            retried     <= 1'b1;
          end else
`endif
          begin
            state          <= ST_DONE;
            calib_busy     <= 1'b0;
            calib_done     <= 1'b1;
            calib_fail     <= |bit_fail;
            calib_clk0_sel <= bit_sel;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nand_phy_calib_ctrl.md
# nand_phy_calib_ctrl

Read-capture calibration sequencer for the NAND PHY DQ lanes. On request it resets the DQS-clocked IDDR capture flops and enables the read-training pattern. It then counts toggle errors on the four per-bit phase samples (0/90/180/270) that the DQ IOBs return, and picks for each bit whether the rising read data is taken from the clk0 or clk180 capture path (`calib_clk0_sel`). It sits in the clk0 domain between the NAND PHY top and the DQ IOB array.

## Interface
- `DQ_WIDTH`, 8, number of DQ bits calibrated.
- `NUM_SAMPLES`, 64, number of compared samples per pass.
- `ERR_THRESH`, 4, maximum tolerated errors on the selected phase.
- `RST_CYCLES`, 4, cycles `dq_iddr_rst` is held high per pass.
- `SETTLE_CYCLES`, 8, cycles between training enable and first sample.

Ports:
- `clk0`  in  1  PHY base clock; all logic on its rising edge.
- `rst0`  in  1  asynchronous, active-high reset.
- `calib_start`  in  1  single-cycle request to start calibration.
- `calib_busy`  out  1  high from the first cycle after an accepted start until `calib_done`.
- `calib_done`  out  1  level; high once a result is valid, cleared on the next accepted start.
- `calib_fail`  out  1  valid while `calib_done` is high; some bit failed.
- `calib_train_en`  out  1  requests the NAND read-training toggle pattern.
- `dq_iddr_rst`  out  1  to every DQ IOB; gates the IDDR clock enable.
- `calib_dq_rise_0/_90/_180/_270`  in  DQ_WIDTH each  phase samples from the DQ IOBs, already synchronised to clk0.
- `calib_clk0_sel`  out  DQ_WIDTH  per bit: 1 = use the clk0 capture path, 0 = use the clk180 path.

## Operation
- Reset values: `dq_iddr_rst`=1, `calib_clk0_sel`=all 1, and `calib_busy`/`calib_done`/`calib_fail`/`calib_train_en`=0. The FSM is in IDLE.
- FSM states: IDLE, RST_IDDR, SETTLE, SAMPLE, DECIDE, DONE.
- `calib_start` is accepted only in IDLE or DONE. It is ignored in every other state.
- IDLE/DONE → RST_IDDR on an accepted start. This state drives `dq_iddr_rst`=1, clears all error counters and lasts RST_CYCLES cycles.
- RST_IDDR → SETTLE. SETTLE drives `dq_iddr_rst`=0 and `calib_train_en`=1 for SETTLE_CYCLES cycles.
- SETTLE → SAMPLE, which lasts NUM_SAMPLES+1 cycles.
  - The first SAMPLE cycle only loads the previous-sample registers.
  - Each later cycle compares, per bit and per phase, the current sample against the previous one.
  - An unchanged value is one error, because the training pattern toggles rising data every clk0 cycle.
- Counter width is clog2(NUM_SAMPLES+1). Counters saturate at NUM_SAMPLES and never wrap.
- SAMPLE → DECIDE, one cycle, `calib_train_en`=0. Decision per bit:
  - `sel` = 1 if err0 ≤ err180, else 0. A tie resolves to the clk0 path.
  - The bit fails if min(err0, err180) > ERR_THRESH.
  - The bit also fails if all four counts equal NUM_SAMPLES (stuck lane).
- DECIDE → DONE. `calib_clk0_sel` is updated in this transition only. It holds its value at all other times, including across a failed result.
- In DONE, `calib_done`=1 and `calib_fail` = OR of the per-bit fails.
- `rst0` asserted in any state returns the FSM to IDLE immediately and forces all reset values. No partial result is kept.

## Timing
- Start sampled high at cycle 0 in IDLE: `calib_busy` rises at cycle 1.
- `calib_done` rises at cycle T = RST_CYCLES + SETTLE_CYCLES + NUM_SAMPLES + 3. With defaults, T = 79.
- `calib_busy` falls in the same cycle `calib_done` rises.
- `calib_clk0_sel` changes in the same cycle `calib_done` rises.
- A start in DONE clears `calib_done` and `calib_fail` at cycle 1.
- Phase inputs carry their own IOB synchroniser latency. The decision depends only on consecutive-sample comparisons, so that latency has no effect.

## Configuration
- `NAND_CALIB_RETRY_EN` defined:
  - A failing DECIDE in the first pass goes straight to RST_IDDR for one more full pass, without passing through DONE.
  - The error counters are cleared for the second pass.
  - `calib_done` rises at 2T−1 (157 with defaults). The second-pass result is final.
- Macro undefined: one pass only, and a fail is reported directly.

## Structure
- Package `nand_phy_calib_pkg` holds:
  - the state enum;
  - phase index constants PH_0/PH_90/PH_180/PH_270;
  - the counter-width function.
- Sub-module `nand_phy_calib_bit_cnt` is instantiated per bit. It contains the four previous-sample registers, the four saturating error counters and the per-bit decide logic, and outputs `sel` and `fail`.

## Test plan
All scenarios use default parameters.
- **Clean toggle:** all bits toggle on every phase → `calib_done` at cycle 79, `calib_fail`=0, `calib_clk0_sel`=8'hFF.
- **Bad clk0 phase on one bit:** bit 3 phase 0 held constant (err0=64) while phase 180 toggles cleanly → `calib_clk0_sel`=8'hF7, `calib_fail`=0.
- **Both phases marginal:** bit 5 with err0=10 and err180=6 → `calib_clk0_sel[5]`=0, `calib_fail`=1 (retry macro off).
- **Stuck lane:** bit 0 stuck at 1 on all phases → `calib_fail`=1 and `calib_clk0_sel[0]` = 1 (tie).
- **Reset mid-operation:** `rst0` pulsed at cycle 40 (SAMPLE) → in the same cycle `calib_busy`=0 and `dq_iddr_rst`=1; `calib_done` never rises; a subsequent start completes normally at cycle 79.
- **Retry (macro on):** first-pass bit 2 err0=err180=20, second pass clean → `calib_done` at cycle 157, `calib_fail`=0, `calib_clk0_sel`=8'hFF.
